// File: rtl/filavg_axil_slave.sv
// AXI4-Lite slave for the FilAVG IP: CTRL/SAMPLE/AVG/STATUS registers in front of a
// power-of-two-window moving-average filter with independent write and read channel FSMs.
module filavg_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int SAMPLE_WIDTH       = 16,
  parameter int MAX_LOG2_N         = 3
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int SUM_WIDTH  = SAMPLE_WIDTH + MAX_LOG2_N;
  localparam int DEPTH      = 1 << MAX_LOG2_N;
  localparam int FILL_WIDTH = MAX_LOG2_N + 1;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

  wr_state_t wr_state_r, wr_next_s;
  rd_state_t rd_state_r, rd_next_s;
  logic      wr_fire_s, bvalid_s, rd_fire_s, rvalid_s;

  logic                          en_r;
  logic [1:0]                    k_r;
  logic [SAMPLE_WIDTH-1:0]       sample_r;
  logic [SAMPLE_WIDTH-1:0]       sh_r [DEPTH];
  logic [SUM_WIDTH-1:0]          sum_r;
  logic [SUM_WIDTH-1:0]          avg_r;
  logic [FILL_WIDTH-1:0]         fill_r;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r;

  logic [1:0]                    wr_addr_s;
  logic                          ctrl_wr_s, clr_s, sample_wr_s, advance_s, full_s;
  logic [SAMPLE_WIDTH-1:0]       sample_new_s, tap_s;
  logic [FILL_WIDTH-1:0]         n_s, n_m1_s;
  logic [SUM_WIDTH-1:0]          sum_next_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux_s;
  logic                          unused_s;

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                      S_AXI_WDATA[31:16], S_AXI_WDATA[7:6], S_AXI_WDATA[3:2], S_AXI_WSTRB[3:2]};

  // Write FSM state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) wr_state_r <= W_IDLE;
    else                wr_state_r <= wr_next_s;
  end

  // Write FSM next state
  always_comb begin
    wr_next_s = wr_state_r;
    case (wr_state_r)
      W_IDLE:  if (S_AXI_AWVALID && S_AXI_WVALID) wr_next_s = W_RESP; else wr_next_s = W_IDLE;
      W_RESP:  if (S_AXI_BREADY) wr_next_s = W_IDLE; else wr_next_s = W_RESP;
      default: wr_next_s = W_IDLE;
    endcase
  end

  // Write FSM outputs: AW and W are accepted together in a single cycle
  always_comb begin
    wr_fire_s = 1'b0;
    bvalid_s  = 1'b0;
    case (wr_state_r)
      W_IDLE:  wr_fire_s = S_AXI_AWVALID && S_AXI_WVALID;
      W_RESP:  bvalid_s  = 1'b1;
      default: bvalid_s  = 1'b0;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rd_state_r <= R_IDLE;
    else                rd_state_r <= rd_next_s;
  end

  // Read FSM next state
  always_comb begin
    rd_next_s = rd_state_r;
    case (rd_state_r)
      R_IDLE:  if (S_AXI_ARVALID) rd_next_s = R_DATA; else rd_next_s = R_IDLE;
      R_DATA:  if (S_AXI_RREADY) rd_next_s = R_IDLE; else rd_next_s = R_DATA;
      default: rd_next_s = R_IDLE;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    rd_fire_s = 1'b0;
    rvalid_s  = 1'b0;
    case (rd_state_r)
      R_IDLE:  rd_fire_s = S_AXI_ARVALID;
      R_DATA:  rvalid_s  = 1'b1;
      default: rvalid_s  = 1'b0;
    endcase
  end

  assign S_AXI_AWREADY = wr_fire_s;
  assign S_AXI_WREADY  = wr_fire_s;
  assign S_AXI_BVALID  = bvalid_s;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = rd_fire_s;
  assign S_AXI_RVALID  = rvalid_s;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata_r;

  // Register decode; a CTRL write clears the filter on CLR=1 or on any change of K
  assign wr_addr_s   = S_AXI_AWADDR[3:2];
  assign ctrl_wr_s   = wr_fire_s && (wr_addr_s == 2'd0) && S_AXI_WSTRB[0];
  assign clr_s       = ctrl_wr_s && (S_AXI_WDATA[1] || (S_AXI_WDATA[5:4] != k_r));
  assign sample_wr_s = wr_fire_s && (wr_addr_s == 2'd1);
  assign advance_s   = sample_wr_s && en_r;

  // Byte-lane merge of the incoming sample
  always_comb begin
    sample_new_s = sample_r;
    for (int b = 0; b < SAMPLE_WIDTH / 8; b++) begin
      sample_new_s[b*8 +: 8] = S_AXI_WSTRB[b] ? S_AXI_WDATA[b*8 +: 8] : sample_r[b*8 +: 8];
    end
  end

  assign n_s        = FILL_WIDTH'(1) << k_r;
  assign n_m1_s     = n_s - FILL_WIDTH'(1);
  assign tap_s      = sh_r[n_m1_s[MAX_LOG2_N-1:0]];
  assign sum_next_s = sum_r
                    + {{MAX_LOG2_N{sample_new_s[SAMPLE_WIDTH-1]}}, sample_new_s}
                    - {{MAX_LOG2_N{tap_s[SAMPLE_WIDTH-1]}}, tap_s};
  assign full_s     = (fill_r == n_s);

  // Control and sample registers
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      en_r     <= 1'b0;
      k_r      <= 2'd0;
      sample_r <= '0;
    end else begin
      if (ctrl_wr_s) begin
        en_r <= S_AXI_WDATA[0];
        k_r  <= S_AXI_WDATA[5:4];
      end
      if (sample_wr_s) sample_r <= sample_new_s;
    end
  end

  // Filter datapath: shift register, running sum, average and fill level
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < DEPTH; i++) sh_r[i] <= '0;
      sum_r  <= '0;
      avg_r  <= '0;
      fill_r <= '0;
    end else if (clr_s) begin
      for (int i = 0; i < DEPTH; i++) sh_r[i] <= '0;
      sum_r  <= '0;
      avg_r  <= '0;
      fill_r <= '0;
    end else if (advance_s) begin
      for (int i = DEPTH - 1; i > 0; i--) sh_r[i] <= sh_r[i-1];
      sh_r[0] <= sample_new_s;
      sum_r   <= sum_next_s;
      avg_r   <= SUM_WIDTH'($signed(sum_next_s) >>> k_r);
      fill_r  <= full_s ? fill_r : fill_r + FILL_WIDTH'(1);
    end
  end

  // Read data mux, sampled from pre-write register values
  always_comb begin
    case (S_AXI_ARADDR[3:2])
      2'd0:    rd_mux_s = {26'd0, k_r, 2'b00, 1'b0, en_r};
      2'd1:    rd_mux_s = {{(32-SAMPLE_WIDTH){sample_r[SAMPLE_WIDTH-1]}}, sample_r};
      2'd2:    rd_mux_s = {{(32-SUM_WIDTH){avg_r[SUM_WIDTH-1]}}, avg_r};
      2'd3:    rd_mux_s = {23'd0, full_s, {(8-FILL_WIDTH){1'b0}}, fill_r};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Read data holding register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)  rdata_r <= '0;
    else if (rd_fire_s)  rdata_r <= rd_mux_s;
  end

endmodule

// File: tb/tb_filavg_axil_slave.sv
// Directed bench for filavg_axil_slave: register map, filter arithmetic, clear rules,
// strobes, enable gating and handshake backpressure against hand-computed values.
module tb_filavg_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = 4'd0;
  logic [2:0]  awprot = 3'd0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = 4'd0;
  logic [2:0]  arprot = 3'd0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  filavg_axil_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    while (!(awready && wready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val("wr_ready", {30'd0, awready, wready}, 32'd3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check_val("wr_bvalid_bresp", {29'd0, bvalid, bresp}, 32'h4);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check_val("wr_bvalid_clear", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    n = 0;
    araddr = a; arvalid = 1'b1;
    #1;
    while (!arready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val("rd_arready", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check_val("rd_rvalid_rresp", {29'd0, rvalid, rresp}, 32'h4);
    d = rdata;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    check_val(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] held;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outputs", {24'd0, awready, wready, bvalid, arready, rvalid, bresp[0], rresp[0], 1'b0}, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    read_check("rst_ctrl", 4'h0, 32'h0);
    read_check("rst_sample", 4'h4, 32'h0);
    read_check("rst_avg", 4'h8, 32'h0);
    read_check("rst_status", 4'hC, 32'h0);

    // Positive stream, N = 4
    axi_write(4'h0, 32'h21, 4'hF);
    read_check("ctrl_21", 4'h0, 32'h21);
    axi_write(4'h4, 32'd4, 4'hF);
    read_check("pos_avg1", 4'h8, 32'd1);
    axi_write(4'h4, 32'd8, 4'hF);
    read_check("pos_avg2", 4'h8, 32'd3);
    read_check("pos_status2", 4'hC, 32'h002);
    axi_write(4'h4, 32'd12, 4'hF);
    read_check("pos_avg3", 4'h8, 32'd6);
    axi_write(4'h4, 32'd16, 4'hF);
    read_check("pos_avg4", 4'h8, 32'd10);
    read_check("pos_status4", 4'hC, 32'h104);
    axi_write(4'h4, 32'd20, 4'hF);
    read_check("pos_avg5", 4'h8, 32'd14);
    read_check("pos_status5", 4'hC, 32'h104);
    read_check("pos_sample", 4'h4, 32'd20);

    // Write backpressure to a read-only address, with a second pair waiting
    awaddr = 4'hC; wdata = 32'hDEAD; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val("bp_first_ready", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check_val("bp_hold", {29'd0, bvalid, awready, wready}, 32'h4);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check_val("bp_second_ready", {30'd0, awready, wready}, 32'd3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check_val("bp_second_bvalid", {31'd0, bvalid}, 32'd1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    read_check("bp_avg_kept", 4'h8, 32'd14);

    // Read backpressure: RDATA stable while RREADY low
    araddr = 4'h8; arvalid = 1'b1;
    #1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    held = rdata;
    check_val("rbp_first", held, 32'd14);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_val("rbp_hold", {rdata[30:0], rvalid}, {held[30:0], 1'b1});
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;

    // Negative stream, N = 2 (K change clears)
    axi_write(4'h0, 32'h11, 4'hF);
    read_check("neg_clr_avg", 4'h8, 32'h0);
    read_check("neg_clr_status", 4'hC, 32'h0);
    axi_write(4'h4, 32'h0000FFFD, 4'hF);
    read_check("neg_avg1", 4'h8, 32'hFFFFFFFE);
    read_check("neg_sample", 4'h4, 32'hFFFFFFFD);
    axi_write(4'h4, 32'h0000FFFB, 4'hF);
    read_check("neg_avg2", 4'h8, 32'hFFFFFFFC);
    read_check("neg_status", 4'hC, 32'h102);

    // CLR is a pulse; K change back to 2
    axi_write(4'h0, 32'h23, 4'hF);
    read_check("clr_avg", 4'h8, 32'h0);
    read_check("clr_status", 4'hC, 32'h0);
    read_check("clr_ctrl", 4'h0, 32'h21);
    axi_write(4'h4, 32'd100, 4'hF);
    axi_write(4'h4, 32'd200, 4'hF);
    read_check("clr_avg2", 4'h8, 32'd75);
    // CLR alone, K unchanged
    axi_write(4'h0, 32'h23, 4'hF);
    read_check("clr_only_avg", 4'h8, 32'h0);
    read_check("clr_only_status", 4'hC, 32'h0);
    axi_write(4'h4, 32'd40, 4'hF);
    read_check("clr_only_avg2", 4'h8, 32'd10);
    read_check("clr_only_status2", 4'hC, 32'h001);
    axi_write(4'h0, 32'h31, 4'hF);
    read_check("k3_status", 4'hC, 32'h0);
    read_check("k3_avg", 4'h8, 32'h0);
    read_check("k3_ctrl", 4'h0, 32'h31);

    // Strobes and enable
    axi_write(4'h0, 32'hFFFFFF00, 4'h1);
    read_check("strb_ctrl", 4'h0, 32'h0);
    axi_write(4'h0, 32'h01, 4'hF);
    axi_write(4'h4, 32'd9, 4'hF);
    read_check("n1_avg", 4'h8, 32'd9);
    read_check("n1_status", 4'hC, 32'h101);
    axi_write(4'h0, 32'h00, 4'hF);
    axi_write(4'h4, 32'd7, 4'hF);
    read_check("en0_sample", 4'h4, 32'd7);
    read_check("en0_avg", 4'h8, 32'd9);
    read_check("en0_status", 4'hC, 32'h101);
    axi_write(4'h8, 32'h1234, 4'hF);
    read_check("ro_avg", 4'h8, 32'd9);
    axi_write(4'h4, 32'h0000ABCD, 4'h2);
    read_check("strb_sample", 4'h4, 32'hFFFFAB07);
    read_check("strb_avg", 4'h8, 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
